// File: rtl/FetchUnitTypes.sv
// Shared fetch-unit types: I-cache refill FSM states and line-offset sizing.
package FetchUnitTypes;

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_REQ   = 2'd1,
        FILL_WAIT  = 2'd2,
        FILL_WRITE = 2'd3
    } ICacheFillStatePath;

    localparam int unsigned DEFAULT_LINE_BEATS = 4;
    localparam int unsigned DEFAULT_BEAT_BITS  = 32;

    // Number of byte-offset bits inside one cache line.
    function automatic int unsigned line_offset_width(input int unsigned beats,
                                                      input int unsigned beat_bits);
        return $clog2(beats * beat_bits / 8);
    endfunction

    localparam int unsigned LINE_OFFSET_WIDTH =
        line_offset_width(DEFAULT_LINE_BEATS, DEFAULT_BEAT_BITS);

endpackage

// File: rtl/icache_fill_line_buffer.sv
// Assembles in-order response beats into one cache line; flags the final beat.
module icache_fill_line_buffer
    import FetchUnitTypes::*;
#(
    parameter int unsigned MEM_DATA_WIDTH = DEFAULT_BEAT_BITS,
    parameter int unsigned LINE_BEATS     = DEFAULT_LINE_BEATS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_beat_valid,
    input  logic [MEM_DATA_WIDTH-1:0]          i_beat_data,
    output logic [LINE_BEATS*MEM_DATA_WIDTH-1:0] o_line_data,
    output logic                               o_last_beat_c
);

    localparam int unsigned CNT_W = $clog2(LINE_BEATS);

    logic [CNT_W-1:0]                   r_cnt;
    logic [LINE_BEATS*MEM_DATA_WIDTH-1:0] r_data;

    // Beat i lands in slot i; counter wraps naturally since LINE_BEATS is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_data <= '0;
        end else if (i_beat_valid) begin
            r_cnt <= r_cnt + CNT_W'(1);
            for (int unsigned i = 0; i < LINE_BEATS; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    r_data[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= i_beat_data;
                end
            end
        end
    end

    assign o_line_data   = r_data;
    assign o_last_beat_c = i_beat_valid && (r_cnt == CNT_W'(LINE_BEATS - 1));

endmodule

// File: rtl/icache_fill_ctrl.sv
// I-cache line refill controller: miss -> memory request -> beat collection -> line write.
// Optional RSD_ICACHE_FILL_PERF_COUNTER_EN adds saturating miss / stall-cycle counters.
module icache_fill_ctrl
    import FetchUnitTypes::*;
#(
    parameter int unsigned PHY_ADDR_WIDTH = 32,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned LINE_BEATS     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 missValid,
    input  logic [PHY_ADDR_WIDTH-1:0]            missAddr,
    input  logic                                 flush,
    output logic                                 fetchStall,
    output logic                                 memReqValid,
    input  logic                                 memReqReady,
    output logic [PHY_ADDR_WIDTH-1:0]            memReqAddr,
    input  logic                                 memRspValid,
    input  logic [MEM_DATA_WIDTH-1:0]            memRspData,
    output logic                                 fillWE,
    output logic [PHY_ADDR_WIDTH-1:0]            fillAddr,
    output logic [LINE_BEATS*MEM_DATA_WIDTH-1:0] fillData,
    output logic                                 busy
`ifdef RSD_ICACHE_FILL_PERF_COUNTER_EN
    ,
    output logic [31:0]                          perfMissCount,
    output logic [31:0]                          perfStallCycles
`endif
);

    localparam int unsigned OFF_W = line_offset_width(LINE_BEATS, MEM_DATA_WIDTH);
    localparam logic [PHY_ADDR_WIDTH-1:0] OFF_MASK =
        PHY_ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    ICacheFillStatePath        r_state;
    ICacheFillStatePath        w_next_state;
    logic [PHY_ADDR_WIDTH-1:0] r_addr;
    logic                      w_miss_accept;
    logic                      w_beat_valid;
    logic                      w_last_beat;

    assign w_miss_accept = (r_state == FILL_IDLE) && missValid && !flush;
    assign w_beat_valid  = (r_state == FILL_WAIT) && memRspValid;

    icache_fill_line_buffer #(
        .MEM_DATA_WIDTH (MEM_DATA_WIDTH),
        .LINE_BEATS     (LINE_BEATS)
    ) u_line_buffer (
        .clk            (clk),
        .rst            (rst),
        .i_beat_valid   (w_beat_valid),
        .i_beat_data    (memRspData),
        .o_line_data    (fillData),
        .o_last_beat_c  (w_last_beat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A request accepted in the same cycle as a flush is already in flight, so it must drain.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL_IDLE:  if (w_miss_accept) w_next_state = FILL_REQ;
            FILL_REQ: begin
                if (memReqReady)  w_next_state = FILL_WAIT;
                else if (flush)   w_next_state = FILL_IDLE;
            end
            FILL_WAIT:  if (w_last_beat) w_next_state = FILL_WRITE;
            FILL_WRITE: w_next_state = FILL_IDLE;
            default:    w_next_state = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
        end else if (w_miss_accept) begin
            r_addr <= missAddr & ~OFF_MASK;
        end
    end

    assign busy        = (r_state != FILL_IDLE);
    assign memReqValid = (r_state == FILL_REQ);
    assign memReqAddr  = r_addr;
    assign fillWE      = (r_state == FILL_WRITE);
    assign fillAddr    = r_addr;
    assign fetchStall  = busy || ((r_state == FILL_IDLE) && missValid);

`ifdef RSD_ICACHE_FILL_PERF_COUNTER_EN
    logic [31:0] r_perf_miss;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_miss  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_miss_accept && (r_perf_miss != '1)) r_perf_miss <= r_perf_miss + 32'd1;
            if (busy && (r_perf_stall != '1))         r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perfMissCount   = r_perf_miss;
    assign perfStallCycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed self-checking bench for icache_fill_ctrl (default 32-bit address, 4 x 32-bit beats).
module tb_icache_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         missValid;
    logic [31:0]  missAddr;
    logic         flush;
    logic         fetchStall;
    logic         memReqValid;
    logic         memReqReady;
    logic [31:0]  memReqAddr;
    logic         memRspValid;
    logic [31:0]  memRspData;
    logic         fillWE;
    logic [31:0]  fillAddr;
    logic [127:0] fillData;
    logic         busy;
`ifdef RSD_ICACHE_FILL_PERF_COUNTER_EN
    logic [31:0]  perfMissCount;
    logic [31:0]  perfStallCycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_fill_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .missValid   (missValid),
        .missAddr    (missAddr),
        .flush       (flush),
        .fetchStall  (fetchStall),
        .memReqValid (memReqValid),
        .memReqReady (memReqReady),
        .memReqAddr  (memReqAddr),
        .memRspValid (memRspValid),
        .memRspData  (memRspData),
        .fillWE      (fillWE),
        .fillAddr    (fillAddr),
        .fillData    (fillData),
        .busy        (busy)
`ifdef RSD_ICACHE_FILL_PERF_COUNTER_EN
        ,
        .perfMissCount   (perfMissCount),
        .perfStallCycles (perfStallCycles)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        missValid   = 1'b0;
        missAddr    = 32'h0;
        flush       = 1'b0;
        memReqReady = 1'b0;
        memRspValid = 1'b0;
        memRspData  = 32'h0;
    endtask

    // Four consecutive beats starting from the first WAIT cycle; returns in the WRITE cycle.
    task automatic send_beats(input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [31:0] b3);
        logic [31:0] beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        for (int i = 0; i < 4; i++) begin
            memRspValid = 1'b1;
            memRspData  = beats[i];
            tick();
        end
        memRspValid = 1'b0;
        memRspData  = 32'h0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (memReqValid !== 1'b0) begin errors++; $display("FAIL reset_reqvalid: got %b want 0", memReqValid); end
        checks++; if (fillWE !== 1'b0) begin errors++; $display("FAIL reset_fillwe: got %b want 0", fillWE); end
        checks++; if (fillData !== 128'h0) begin errors++; $display("FAIL reset_filldata: got %h want 0", fillData); end
        checks++; if (memReqAddr !== 32'h0) begin errors++; $display("FAIL reset_reqaddr: got %h want 0", memReqAddr); end
        checks++; if (fetchStall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", fetchStall); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_fill;
        missValid = 1'b1;
        missAddr  = 32'h0000_1234;
        #1;
        checks++; if (fetchStall !== 1'b1) begin errors++; $display("FAIL basic_stall_comb: got %b want 1", fetchStall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
        tick();
        missValid   = 1'b0;
        memReqReady = 1'b1;
        checks++; if (memReqValid !== 1'b1) begin errors++; $display("FAIL basic_reqvalid: got %b want 1", memReqValid); end
        checks++; if (memReqAddr !== 32'h0000_1230) begin errors++; $display("FAIL basic_reqaddr: got %h want 00001230", memReqAddr); end
        tick();
        memReqReady = 1'b0;
        checks++; if (memReqValid !== 1'b0) begin errors++; $display("FAIL basic_wait_reqvalid: got %b want 0", memReqValid); end
        send_beats(32'hA, 32'hB, 32'hC, 32'hD);
        checks++; if (fillWE !== 1'b1) begin errors++; $display("FAIL basic_fillwe: got %b want 1", fillWE); end
        checks++; if (fillAddr !== 32'h0000_1230) begin errors++; $display("FAIL basic_filladdr: got %h want 00001230", fillAddr); end
        checks++; if (fillData !== 128'h0000000D_0000000C_0000000B_0000000A) begin errors++; $display("FAIL basic_filldata: got %h want 0000000d0000000c0000000b0000000a", fillData); end
        checks++; if (fetchStall !== 1'b1) begin errors++; $display("FAIL basic_stall_write: got %b want 1", fetchStall); end
        tick();
        checks++; if (fillWE !== 1'b0) begin errors++; $display("FAIL basic_fillwe_once: got %b want 0", fillWE); end
        checks++; if (fetchStall !== 1'b0) begin errors++; $display("FAIL basic_stall_drop: got %b want 0", fetchStall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    endtask

    task automatic test_req_backpressure;
        missValid = 1'b1;
        missAddr  = 32'h0000_2008;
        tick();
        missValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            memRspValid = 1'b1;
            memRspData  = 32'hDEAD_0000 + 32'(i);
            checks++; if (memReqValid !== 1'b1) begin errors++; $display("FAIL bp_reqvalid[%0d]: got %b want 1", i, memReqValid); end
            checks++; if (memReqAddr !== 32'h0000_2000) begin errors++; $display("FAIL bp_reqaddr[%0d]: got %h want 00002000", i, memReqAddr); end
            tick();
        end
        memRspValid = 1'b0;
        memReqReady = 1'b1;
        checks++; if (memReqValid !== 1'b1) begin errors++; $display("FAIL bp_reqvalid_ready: got %b want 1", memReqValid); end
        tick();
        memReqReady = 1'b0;
        checks++; if (memReqValid !== 1'b0) begin errors++; $display("FAIL bp_in_wait: got %b want 0", memReqValid); end
        send_beats(32'h1, 32'h2, 32'h3, 32'h4);
        checks++; if (fillWE !== 1'b1) begin errors++; $display("FAIL bp_fillwe: got %b want 1", fillWE); end
        checks++; if (fillData !== 128'h00000004_00000003_00000002_00000001) begin errors++; $display("FAIL bp_filldata: got %h want 00000004000000030000000200000001", fillData); end
        tick();
    endtask

    task automatic test_flush_req;
        missValid = 1'b1;
        missAddr  = 32'h0000_3000;
        tick();
        missValid = 1'b0;
        flush     = 1'b1;
        checks++; if (memReqValid !== 1'b1) begin errors++; $display("FAIL fr_reqvalid: got %b want 1", memReqValid); end
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fr_to_idle: got %b want 0", busy); end
        for (int i = 0; i < 4; i++) begin
            memRspValid = 1'b1;
            memRspData  = 32'hEEEE_0000 + 32'(i);
            tick();
            checks++; if (fillWE !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fr_stray[%0d]: got fillWE=%b busy=%b want 0 0", i, fillWE, busy); end
        end
        memRspValid = 1'b0;
        // flush and miss together in IDLE: nothing latched
        missValid = 1'b1;
        flush     = 1'b1;
        missAddr  = 32'h0000_3100;
        tick();
        missValid = 1'b0;
        flush     = 1'b0;
        checks++; if (busy !== 1'b0 || memReqValid !== 1'b0) begin errors++; $display("FAIL fr_flush_wins: got busy=%b reqvalid=%b want 0 0", busy, memReqValid); end
        // flush coincident with ready: request counts as issued
        missValid = 1'b1;
        missAddr  = 32'h0000_3200;
        tick();
        missValid   = 1'b0;
        flush       = 1'b1;
        memReqReady = 1'b1;
        tick();
        flush       = 1'b0;
        memReqReady = 1'b0;
        checks++; if (busy !== 1'b1 || memReqValid !== 1'b0) begin errors++; $display("FAIL fr_ready_wins: got busy=%b reqvalid=%b want 1 0", busy, memReqValid); end
        send_beats(32'h51, 32'h52, 32'h53, 32'h54);
        checks++; if (fillWE !== 1'b1 || fillAddr !== 32'h0000_3200) begin errors++; $display("FAIL fr_ready_fill: got fillWE=%b addr=%h want 1 00003200", fillWE, fillAddr); end
        checks++; if (fillData !== 128'h00000054_00000053_00000052_00000051) begin errors++; $display("FAIL fr_ready_data: got %h want 00000054000000530000005200000051", fillData); end
        tick();
    endtask

    task automatic test_flush_wait;
        missValid = 1'b1;
        missAddr  = 32'h0000_4444;
        tick();
        missValid   = 1'b0;
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        memRspValid = 1'b1;
        memRspData  = 32'h61;
        tick();
        memRspData  = 32'h62;
        tick();
        memRspData  = 32'h63;
        flush       = 1'b1;
        missValid   = 1'b1;
        missAddr    = 32'h0000_9000;
        #1;
        checks++; if (fetchStall !== 1'b1) begin errors++; $display("FAIL fw_stall_wait: got %b want 1", fetchStall); end
        tick();
        flush      = 1'b0;
        missValid  = 1'b0;
        memRspData = 32'h64;
        tick();
        memRspValid = 1'b0;
        missValid   = 1'b1;
        checks++; if (fillWE !== 1'b1 || fillAddr !== 32'h0000_4440) begin errors++; $display("FAIL fw_fill: got fillWE=%b addr=%h want 1 00004440", fillWE, fillAddr); end
        checks++; if (fillData !== 128'h00000064_00000063_00000062_00000061) begin errors++; $display("FAIL fw_data: got %h want 00000064000000630000006200000061", fillData); end
        tick();
        // miss raised during WRITE was ignored; retry is now visible combinationally
        checks++; if (busy !== 1'b0 || memReqValid !== 1'b0) begin errors++; $display("FAIL fw_miss_ignored: got busy=%b reqvalid=%b want 0 0", busy, memReqValid); end
        checks++; if (fetchStall !== 1'b1) begin errors++; $display("FAIL fw_stall_retry: got %b want 1", fetchStall); end
        missValid = 1'b0;
        #1;
        checks++; if (fetchStall !== 1'b0) begin errors++; $display("FAIL fw_stall_clear: got %b want 0", fetchStall); end
        tick();
    endtask

    task automatic test_reset_mid_fill;
        missValid = 1'b1;
        missAddr  = 32'h0000_5000;
        tick();
        missValid   = 1'b0;
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        memRspValid = 1'b1;
        memRspData  = 32'h71;
        tick();
        memRspData  = 32'h72;
        tick();
        memRspData  = 32'h73;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || fillWE !== 1'b0 || memReqValid !== 1'b0) begin errors++; $display("FAIL rm_outputs: got busy=%b fillWE=%b reqvalid=%b want 0 0 0", busy, fillWE, memReqValid); end
        checks++; if (fillData !== 128'h0 || fillAddr !== 32'h0) begin errors++; $display("FAIL rm_data: got data=%h addr=%h want 0 0", fillData, fillAddr); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            memRspData = 32'hEE + 32'(i);
            tick();
            checks++; if (busy !== 1'b0 || fillWE !== 1'b0) begin errors++; $display("FAIL rm_stray[%0d]: got busy=%b fillWE=%b want 0 0", i, busy, fillWE); end
        end
        memRspValid = 1'b0;
        missValid   = 1'b1;
        missAddr    = 32'h0000_0040;
        tick();
        missValid   = 1'b0;
        memReqReady = 1'b1;
        checks++; if (memReqAddr !== 32'h0000_0040) begin errors++; $display("FAIL rm_reqaddr: got %h want 00000040", memReqAddr); end
        tick();
        memReqReady = 1'b0;
        send_beats(32'h11, 32'h22, 32'h33, 32'h44);
        checks++; if (fillWE !== 1'b1 || fillAddr !== 32'h0000_0040) begin errors++; $display("FAIL rm_fill: got fillWE=%b addr=%h want 1 00000040", fillWE, fillAddr); end
        checks++; if (fillData !== 128'h00000044_00000033_00000022_00000011) begin errors++; $display("FAIL rm_filldata: got %h want 00000044000000330000002200000011", fillData); end
        tick();
    endtask

`ifdef RSD_ICACHE_FILL_PERF_COUNTER_EN
    task automatic test_perf_counters;
        rst = 1'b0;
        idle_inputs();
        tick();
        rst = 1'b1;
        checks++; if (perfMissCount !== 32'd0 || perfStallCycles !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d %0d want 0 0", perfMissCount, perfStallCycles); end
        for (int m = 0; m < 2; m++) begin
            missValid = 1'b1;
            missAddr  = 32'h0000_6000 + 32'(m * 16);
            tick();
            missValid = 1'b0;
            tick();
            memReqReady = 1'b1;
            tick();
            memReqReady = 1'b0;
            send_beats(32'h1, 32'h2, 32'h3, 32'h4);
            tick();
        end
        checks++; if (perfMissCount !== 32'd2) begin errors++; $display("FAIL perf_miss: got %0d want 2", perfMissCount); end
        checks++; if (perfStallCycles !== 32'd14) begin errors++; $display("FAIL perf_stall: got %0d want 14", perfStallCycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fill();
        test_req_backpressure();
        test_flush_req();
        test_flush_wait();
        test_reset_mid_fill();
`ifdef RSD_ICACHE_FILL_PERF_COUNTER_EN
        test_perf_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_fill_ctrl.md
ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 SHALL have parameter PHY_ADDR_WIDTH, default 32, physical address width.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 32, memory response beat width.
REQ-003 SHALL have parameter LINE_BEATS, default 4, beats per cache line (power of two, >= 2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port missValid  input  1  I-cache read enabled and missed this cycle.
REQ-007 SHALL have port missAddr  input  PHY_ADDR_WIDTH  fetch head address of the miss.
REQ-008 SHALL have port flush  input  1  fetch redirect / pipeline flush.
REQ-009 SHALL have port fetchStall  output  1  holds the fetch stage.
REQ-010 SHALL have ports memReqValid output 1, memReqReady input 1, memReqAddr output PHY_ADDR_WIDTH  line-fill request handshake.
REQ-011 SHALL have ports memRspValid input 1, memRspData input MEM_DATA_WIDTH  response beats, in order, no backpressure.
REQ-012 SHALL have ports fillWE output 1, fillAddr output PHY_ADDR_WIDTH, fillData output LINE_BEATS*MEM_DATA_WIDTH  I-cache line write.
REQ-013 SHALL have port busy  output  1  state != IDLE.

Function
REQ-014 SHALL implement FSM IDLE, REQ, WAIT, WRITE.
REQ-015 IDLE: missValid=1 -> latch line-aligned missAddr (low log2(LINE_BEATS*MEM_DATA_WIDTH/8) bits zeroed), go REQ.
REQ-016 REQ: memReqValid=1, memReqAddr=latched address; memReqValid/Addr held stable until memReqReady=1, then go WAIT.
REQ-017 WAIT: each memRspValid beat stored at fillData[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH], i = beat counter; counter wraps to 0 after LINE_BEATS-1; last beat -> WRITE.
REQ-018 WRITE: fillWE=1 for exactly one cycle with fillAddr=latched address, then IDLE.
REQ-019 fetchStall = busy OR (state==IDLE AND missValid), combinational.
REQ-020 Latency: miss in cycle N -> memReqValid in N+1; last beat in cycle M -> fillWE in M+1, fetchStall low in M+2 (absent new miss).
REQ-021 flush in REQ before handshake (memReqReady=0 that cycle) -> IDLE next cycle, no write; flush same cycle as memReqReady=1 -> request counts as issued, go WAIT.
REQ-022 flush in WAIT or WRITE -> no effect on sequencing; all beats drained and line written (data valid regardless of redirect).
REQ-023 missValid outside IDLE SHALL be ignored; fetch retries after stall drops.
REQ-024 memRspValid outside WAIT SHALL be ignored; beat counter unchanged.
REQ-025 Same-cycle flush and missValid in IDLE: flush wins, no miss latched.

Reset
REQ-026 On rst=0 asynchronously: state IDLE, beat counter 0, latched address 0, fillData 0, all valid/enable outputs 0.
REQ-027 Reset mid-refill abandons the fill; no fillWE after release; outstanding beats arriving after release ignored (state IDLE).

Configuration
REQ-028 Macro RSD_ICACHE_FILL_PERF_COUNTER_EN defined: adds outputs perfMissCount (32) incremented per accepted miss, perfStallCycles (32) incremented per cycle busy=1; both saturate at all-ones, reset 0.
REQ-029 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-030 FSM state enum ICacheFillStatePath and line-offset width constant SHALL live in FetchUnitTypes package.
REQ-031 Beat assembly SHALL be one sub-module icache_fill_line_buffer (counter, data shift-in, last-beat flag); FSM stays in icache_fill_ctrl.

Verification
REQ-032 Miss 0x0000_1234, memReqReady=1 immediately, beats 0xA,0xB,0xC,0xD consecutive -> memReqAddr 0x0000_1230, fillWE one cycle, fillData 0xD_C_B_A order (beat0 at LSB), stall low 2 cycles after beat 3.
REQ-033 memReqReady held 0 for 5 cycles -> memReqValid and memReqAddr stable all 5 cycles; no WAIT until ready.
REQ-034 flush in REQ with memReqReady=0 -> IDLE next cycle, fillWE never asserted, later stray beats ignored.
REQ-035 flush after beat 1 -> remaining beats collected, fillWE asserted, fetchStall follows REQ-019.
REQ-036 rst=0 during WAIT after 2 beats -> outputs 0 immediately; next miss 0x40 fills cleanly with beat counter from 0.
REQ-037 With RSD_ICACHE_FILL_PERF_COUNTER_EN: two misses of 7 busy cycles each -> perfMissCount 2, perfStallCycles 14.
